led_bit_sequencer: RTL and testbench
====================================

Name: led_bit_sequencer

Overview:
- Upstream request generator for the per-pixel shift-accumulate RAM.
- Takes the thresholded camera pixel stream across NUM_FRAMES consecutive frames and issues one accumulate request per pixel per frame:
  - WRITE_OVER on the first frame.
  - WRITE on later frames.
  - DISABLE for ambiguous-brightness pixels.
- Sequences arm/capture/drain and flags read-modify-write address hazards.

Parameters:
- DEPTH, 57600: pixel count; address width is $clog2(DEPTH).
- NUM_FRAMES, 8: frames per capture sequence, i.e. code bits; range 1..64.
- LUMA_W, 8: luminance width.
- DRAIN_CYCLES, 3: cycles to wait after the last request so the accumulator pipeline empties.

Ports:
- clk_in  in  1  system clock.
- rst_n_in  in  1  asynchronous active-low reset.
- start_in  in  1  pulse; begins a capture sequence when idle.
- abort_in  in  1  pulse; cancels the sequence.
- frame_start_in  in  1  pulse coincident with the first pixel of each frame.
- pixel_valid_in  in  1  pixel qualifier.
- pixel_addr_in  in  $clog2(DEPTH)  linear pixel address.
- luma_in  in  LUMA_W  pixel brightness.
- thresh_hi_in  in  LUMA_W  luma >= this counts as ON.
- thresh_lo_in  in  LUMA_W  luma <= this counts as OFF.
- addr_out  out  $clog2(DEPTH)  request address.
- summand_out  out  1  bit to shift in.
- request_type_out  out  2  accum_request_t.
- request_valid_out  out  1  request strobe.
- frame_idx_out  out  $clog2(NUM_FRAMES+1)  current frame index.
- busy_out  out  1  high from ARM through DRAIN.
- done_out  out  1  one-cycle pulse when the sequence completes.
- hazard_out  out  1  sticky address-hazard flag.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE.
  - addr_out=0, summand_out=0, request_type_out=READ, request_valid_out=0.
  - frame_idx_out=0, busy_out=0, done_out=0, hazard_out=0.
- States:
  - IDLE: start_in -> ARM; clears hazard_out and frame_idx.
  - ARM: waits for frame_start_in. Ignores pixels until then. On frame_start_in -> CAPTURE with frame_idx=0, and that same-cycle pixel is captured.
  - CAPTURE: frame_start_in increments frame_idx. If frame_idx==NUM_FRAMES-1 when frame_start_in arrives -> DRAIN, and that pixel is not captured.
  - DRAIN: counts DRAIN_CYCLES with no requests, then -> IDLE. done_out pulses on the IDLE-entry cycle.
  - abort_in in any non-IDLE state -> IDLE next cycle, no done_out pulse. abort_in has priority over every other event.
  - start_in while busy is ignored.
- Request generation, CAPTURE only, registered, 1-cycle latency from the pixel:
  - Classification:
    - luma >= thresh_hi_in: bit=1.
    - else luma <= thresh_lo_in: bit=0.
    - else: ambiguous.
    - If thresh_lo_in >= thresh_hi_in, the hi compare wins and there is no ambiguous band.
  - Request type:
    - Ambiguous pixel: request_type=DISABLE, summand=0.
    - frame_idx==0: WRITE_OVER with bit.
    - Otherwise: WRITE with bit.
  - pixel_addr_in >= DEPTH: dropped, no request.
  - pixel_valid_in low: request_valid_out=0. The other outputs hold their last value.
- Hazard check:
  - The accumulator reads with 2-cycle latency, so an address equal to either of the two previously issued request addresses (only those with valid set) is a hazard.
  - On a hazard the request is dropped and hazard_out is set. hazard_out stays set until the next start_in accepted in IDLE.
- frame_idx_out holds its final value (NUM_FRAMES-1) through DRAIN and IDLE until the next start_in.
- NUM_FRAMES==1: the second frame_start_in goes directly to DRAIN.

Decomposition:
- Shared package led_pkg holds:
  - accum_request_t (READ=0, WRITE=1, WRITE_OVER=2, DISABLE=3), moved out of the accumulator.
  - seq_state_t (IDLE, ARM, CAPTURE, DRAIN).
- One natural sub-module: luma_classifier, the combinational ON/OFF/ambiguous compare, reused by preview logic.

Test Plan:
1. NUM_FRAMES=3, DEPTH=16, thresh 200/50; start, then 3 frames of 16 pixels with luma=255 -> 16 WRITE_OVER summand=1, then 32 WRITE summand=1. Then DRAIN 3 cycles, done_out one pulse, frame_idx_out=2.
2. Luma 100 at addr 5, frame 0 -> DISABLE at addr 5 summand=0. Luma 10 at addr 6 -> WRITE_OVER summand=0.
3. Pixels valid before the first frame_start_in after start -> no requests. Pixel coincident with frame_start_in -> request 1 cycle later.
4. Addr sequence 4,7,4 on consecutive cycles -> third dropped, hazard_out=1 and sticky. Sequence 4,7,9,4 -> no hazard.
5. abort_in mid-frame 1 -> request_valid_out=0 next cycle, busy_out=0, no done_out. Reset asserted mid-CAPTURE -> all outputs at reset values immediately, without waiting for a clock edge.
6. pixel_addr_in=DEPTH -> no request. start_in during CAPTURE -> ignored, frame_idx unchanged.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types for the structured-light capture path: accumulator request codes,
// sequencer states and the per-pixel brightness class.
package led_pkg;

  typedef enum logic [1:0] {
    READ       = 2'd0,
    WRITE      = 2'd1,
    WRITE_OVER = 2'd2,
    DISABLE    = 2'd3
  } accum_request_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic bit_val;
    logic ambiguous;
  } luma_class_t;

endpackage

// File: rtl/luma_classifier.sv
// Combinational ON/OFF/ambiguous decision for one pixel; zero latency, no flow control.
// When thresh_lo_i >= thresh_hi_i the ON compare wins and no ambiguous band exists.
module luma_classifier
  import led_pkg::*;
#(
  parameter int LUMA_W = 8
) (
  input  logic [LUMA_W-1:0] luma_i,
  input  logic [LUMA_W-1:0] thresh_hi_i,
  input  logic [LUMA_W-1:0] thresh_lo_i,
  output luma_class_t       cls_o
);

  logic is_on;
  logic is_off;

  assign is_on  = (luma_i >= thresh_hi_i);
  assign is_off = !is_on && (luma_i <= thresh_lo_i);

  assign cls_o.bit_val   = is_on;
  assign cls_o.ambiguous = !is_on && !is_off;

endmodule

// File: rtl/led_bit_sequencer.sv
// Turns the thresholded pixel stream of NUM_FRAMES frames into accumulate requests.
// Requests are registered, 1 cycle after the pixel; no backpressure, hazards drop the request.
module led_bit_sequencer
  import led_pkg::*;
#(
  parameter int  DEPTH        = 57600,
  parameter int  NUM_FRAMES   = 8,
  parameter int  LUMA_W       = 8,
  parameter int  DRAIN_CYCLES = 3,
  localparam int AW           = $clog2(DEPTH),
  localparam int FW           = $clog2(NUM_FRAMES + 1)
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              start_in,
  input  logic              abort_in,
  input  logic              frame_start_in,
  input  logic              pixel_valid_in,
  input  logic [AW-1:0]     pixel_addr_in,
  input  logic [LUMA_W-1:0] luma_in,
  input  logic [LUMA_W-1:0] thresh_hi_in,
  input  logic [LUMA_W-1:0] thresh_lo_in,
  output logic [AW-1:0]     addr_out,
  output logic              summand_out,
  output logic [1:0]        request_type_out,
  output logic              request_valid_out,
  output logic [FW-1:0]     frame_idx_out,
  output logic              busy_out,
  output logic              done_out,
  output logic              hazard_out
);

  localparam int             DCW        = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [FW-1:0]  LAST_FRAME = FW'(NUM_FRAMES - 1);
  localparam logic [AW:0]    DEPTH_W    = (AW + 1)'(DEPTH);

  seq_state_t     state_q,     state_d;
  logic [FW-1:0]  frame_idx_q, frame_idx_d;
  logic [DCW-1:0] drain_cnt_q, drain_cnt_d;
  logic           done_q,      done_d;
  logic           hazard_q,    hazard_d;
  logic [AW-1:0]  addr_q,      addr_d;
  logic           vld_q,       vld_d;
  logic           summand_q,   summand_d;
  accum_request_t type_q,      type_d;
  logic [AW-1:0]  addr_prev_q;
  logic           vld_prev_q;

  luma_class_t cls;
  logic        capture;
  logic        in_range;
  logic        hazard_hit;
  logic        candidate;
  logic        issue;

  luma_classifier #(
    .LUMA_W (LUMA_W)
  ) u_classifier (
    .luma_i      (luma_in),
    .thresh_hi_i (thresh_hi_in),
    .thresh_lo_i (thresh_lo_in),
    .cls_o       (cls)
  );

  always_comb begin
    state_d     = state_q;
    frame_idx_d = frame_idx_q;
    drain_cnt_d = drain_cnt_q;
    done_d      = 1'b0;
    capture     = 1'b0;

    if (abort_in && (state_q != IDLE)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_in) begin
            state_d     = ARM;
            frame_idx_d = '0;
          end
        end
        ARM: begin
          if (frame_start_in) begin
            state_d     = CAPTURE;
            frame_idx_d = '0;
            capture     = 1'b1;
          end
        end
        CAPTURE: begin
          if (frame_start_in) begin
            // The frame_start after the last frame ends the sequence; its pixel is not part of the code.
            if (frame_idx_q == LAST_FRAME) begin
              state_d     = DRAIN;
              drain_cnt_d = '0;
            end else begin
              frame_idx_d = frame_idx_q + 1'b1;
              capture     = 1'b1;
            end
          end else begin
            capture = 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt_q == DRAIN_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            drain_cnt_d = drain_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // The accumulator's 2-cycle read latency means the last two issued addresses are still in flight.
  always_comb begin
    in_range   = ({1'b0, pixel_addr_in} < DEPTH_W);
    hazard_hit = (vld_q && (addr_q == pixel_addr_in)) ||
                 (vld_prev_q && (addr_prev_q == pixel_addr_in));
    candidate  = capture && pixel_valid_in && in_range;
    issue      = candidate && !hazard_hit;

    hazard_d = hazard_q;
    if ((state_q == IDLE) && start_in && !abort_in) begin
      hazard_d = 1'b0;
    end else if (candidate && hazard_hit) begin
      hazard_d = 1'b1;
    end

    vld_d     = issue;
    addr_d    = addr_q;
    summand_d = summand_q;
    type_d    = type_q;
    if (issue) begin
      addr_d = pixel_addr_in;
      if (cls.ambiguous) begin
        type_d    = DISABLE;
        summand_d = 1'b0;
      end else begin
        type_d    = (frame_idx_d == '0) ? WRITE_OVER : WRITE;
        summand_d = cls.bit_val;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= IDLE;
      frame_idx_q <= '0;
      drain_cnt_q <= '0;
      done_q      <= 1'b0;
      hazard_q    <= 1'b0;
      addr_q      <= '0;
      vld_q       <= 1'b0;
      summand_q   <= 1'b0;
      type_q      <= READ;
      addr_prev_q <= '0;
      vld_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_idx_q <= frame_idx_d;
      drain_cnt_q <= drain_cnt_d;
      done_q      <= done_d;
      hazard_q    <= hazard_d;
      addr_q      <= addr_d;
      vld_q       <= vld_d;
      summand_q   <= summand_d;
      type_q      <= type_d;
      addr_prev_q <= addr_q;
      vld_prev_q  <= vld_q;
    end
  end

  assign addr_out          = addr_q;
  assign summand_out       = summand_q;
  assign request_type_out  = type_q;
  assign request_valid_out = vld_q;
  assign frame_idx_out     = frame_idx_q;
  assign busy_out          = (state_q != IDLE);
  assign done_out          = done_q;
  assign hazard_out        = hazard_q;

endmodule

// File: tb/tb_led_bit_sequencer.sv
// Directed bench for led_bit_sequencer; expected requests go into a scoreboard queue
// that a negedge monitor drains and compares against the request outputs.
module tb_led_bit_sequencer;
  import led_pkg::*;

  // DEPTH is not a power of two so that an address equal to DEPTH is representable.
  localparam int DEPTH = 12;
  localparam int NF    = 3;
  localparam int LW    = 8;
  localparam int DC    = 3;
  localparam int AW    = $clog2(DEPTH);
  localparam int FW    = $clog2(NF + 1);

  logic          clk_in = 1'b0;
  logic          rst_n_in = 1'b1;
  logic          start_in = 1'b0;
  logic          abort_in = 1'b0;
  logic          frame_start_in = 1'b0;
  logic          pixel_valid_in = 1'b0;
  logic [AW-1:0] pixel_addr_in = '0;
  logic [LW-1:0] luma_in = '0;
  logic [LW-1:0] thresh_hi_in = 8'd200;
  logic [LW-1:0] thresh_lo_in = 8'd50;
  logic [AW-1:0] addr_out;
  logic          summand_out;
  logic [1:0]    request_type_out;
  logic          request_valid_out;
  logic [FW-1:0] frame_idx_out;
  logic          busy_out;
  logic          done_out;
  logic          hazard_out;

  led_bit_sequencer #(
    .DEPTH        (DEPTH),
    .NUM_FRAMES   (NF),
    .LUMA_W       (LW),
    .DRAIN_CYCLES (DC)
  ) dut (
    .clk_in            (clk_in),
    .rst_n_in          (rst_n_in),
    .start_in          (start_in),
    .abort_in          (abort_in),
    .frame_start_in    (frame_start_in),
    .pixel_valid_in    (pixel_valid_in),
    .pixel_addr_in     (pixel_addr_in),
    .luma_in           (luma_in),
    .thresh_hi_in      (thresh_hi_in),
    .thresh_lo_in      (thresh_lo_in),
    .addr_out          (addr_out),
    .summand_out       (summand_out),
    .request_type_out  (request_type_out),
    .request_valid_out (request_valid_out),
    .frame_idx_out     (frame_idx_out),
    .busy_out          (busy_out),
    .done_out          (done_out),
    .hazard_out        (hazard_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int a;
    int s;
    int t;
    int f;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   done_pulses = 0;

  localparam int T_WR  = 1;
  localparam int T_WO  = 2;
  localparam int T_DIS = 3;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic push(input int a, input int s, input int t, input int f);
    exp_t e;
    e.a = a; e.s = s; e.t = t; e.f = f;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input bit fs, input bit vld, input int a, input int l);
    frame_start_in = fs;
    pixel_valid_in = vld;
    pixel_addr_in  = a[AW-1:0];
    luma_in        = l[LW-1:0];
    tick();
    frame_start_in = 1'b0;
    pixel_valid_in = 1'b0;
  endtask

  task automatic pulse_start();
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
  endtask

  always @(negedge clk_in) begin : monitor
    exp_t e;
    if (done_out === 1'b1) done_pulses++;
    if (request_valid_out === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_request: addr=%0d type=%0d while none expected",
                 addr_out, request_type_out);
      end else begin
        e = sb.pop_front();
        chk("req_addr", 64'(addr_out), 64'(e.a));
        chk("req_summand", 64'(summand_out), 64'(e.s));
        chk("req_type", 64'(request_type_out), 64'(e.t));
        chk("req_frame_idx", 64'(frame_idx_out), 64'(e.f));
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    // Reset asserted before any clock edge: outputs must already be at reset values.
    #1 rst_n_in = 1'b0;
    #2;
    chk("rst_addr", 64'(addr_out), 0);
    chk("rst_summand", 64'(summand_out), 0);
    chk("rst_type", 64'(request_type_out), 64'(READ));
    chk("rst_valid", 64'(request_valid_out), 0);
    chk("rst_frame_idx", 64'(frame_idx_out), 0);
    chk("rst_busy", 64'(busy_out), 0);
    chk("rst_done", 64'(done_out), 0);
    chk("rst_hazard", 64'(hazard_out), 0);
    repeat (2) tick();
    rst_n_in = 1'b1;
    tick();

    // Full 3-frame capture of bright pixels.
    pulse_start();
    chk("arm_busy", 64'(busy_out), 1);
    for (int f = 0; f < NF; f++) begin
      for (int a = 0; a < DEPTH; a++) begin
        push(a, 1, (f == 0) ? T_WO : T_WR, f);
        drive(a == 0, 1'b1, a, 255);
      end
    end
    drive(1'b1, 1'b1, 0, 255);
    chk("drain_no_req", 64'(request_valid_out), 0);
    chk("drain_busy_first", 64'(busy_out), 1);
    chk("drain_no_done", 64'(done_out), 0);
    repeat (2) tick();
    chk("drain_busy_last", 64'(busy_out), 1);
    tick();
    chk("idle_busy", 64'(busy_out), 0);
    chk("done_pulse", 64'(done_out), 1);
    chk("final_frame_idx", 64'(frame_idx_out), 2);
    tick();
    chk("done_one_cycle", 64'(done_out), 0);
    chk("done_count_1", 64'(done_pulses), 1);
    chk("sb_drained_1", 64'(sb.size()), 0);

    // Classification boundaries in frame 0.
    pulse_start();
    chk("start_clears_idx", 64'(frame_idx_out), 0);
    push(5, 0, T_DIS, 0);  drive(1'b1, 1'b1, 5, 100);
    push(6, 0, T_WO, 0);   drive(1'b0, 1'b1, 6, 10);
    push(7, 1, T_WO, 0);   drive(1'b0, 1'b1, 7, 200);
    push(8, 0, T_WO, 0);   drive(1'b0, 1'b1, 8, 50);
    push(9, 0, T_DIS, 0);  drive(1'b0, 1'b1, 9, 199);
    push(10, 0, T_DIS, 0); drive(1'b0, 1'b1, 10, 51);
    drive(1'b0, 1'b0, 3, 255);
    chk("invalid_no_req", 64'(request_valid_out), 0);
    chk("invalid_hold_addr", 64'(addr_out), 10);
    chk("invalid_hold_type", 64'(request_type_out), T_DIS);

    // Abort in frame 1 beats a coincident valid pixel.
    push(0, 1, T_WR, 1); drive(1'b1, 1'b1, 0, 255);
    chk("frame1_idx", 64'(frame_idx_out), 1);
    abort_in = 1'b1;
    drive(1'b0, 1'b1, 1, 255);
    abort_in = 1'b0;
    chk("abort_no_req", 64'(request_valid_out), 0);
    chk("abort_busy", 64'(busy_out), 0);
    repeat (5) tick();
    chk("abort_no_done", 64'(done_pulses), 1);

    // Pixels in ARM are ignored; the frame_start pixel is requested one cycle later.
    pulse_start();
    chk("restart_idx", 64'(frame_idx_out), 0);
    drive(1'b0, 1'b1, 2, 255);
    drive(1'b0, 1'b1, 3, 255);
    chk("arm_no_req", 64'(request_valid_out), 0);
    push(3, 1, T_WO, 0); drive(1'b1, 1'b1, 3, 255);
    chk("first_pixel_latency", 64'(request_valid_out), 1);

    // 4,7,9,4 is outside the window; a following 7,4 hits the two-back address.
    push(4, 1, T_WO, 0); drive(1'b0, 1'b1, 4, 255);
    push(7, 1, T_WO, 0); drive(1'b0, 1'b1, 7, 255);
    push(9, 1, T_WO, 0); drive(1'b0, 1'b1, 9, 255);
    push(4, 1, T_WO, 0); drive(1'b0, 1'b1, 4, 255);
    chk("no_hazard_4794", 64'(hazard_out), 0);
    push(7, 1, T_WO, 0); drive(1'b0, 1'b1, 7, 255);
    drive(1'b0, 1'b1, 4, 255);
    chk("hazard_set", 64'(hazard_out), 1);
    chk("hazard_dropped", 64'(request_valid_out), 0);
    push(1, 0, T_WO, 0); drive(1'b0, 1'b1, 1, 10);
    chk("hazard_sticky", 64'(hazard_out), 1);

    // Out-of-range address and start while busy.
    drive(1'b0, 1'b1, DEPTH, 255);
    chk("oob_no_req", 64'(request_valid_out), 0);
    chk("oob_hold_addr", 64'(addr_out), 1);
    start_in = 1'b1;
    push(11, 1, T_WO, 0); drive(1'b0, 1'b1, 11, 255);
    start_in = 1'b0;
    chk("busy_start_idx", 64'(frame_idx_out), 0);
    chk("busy_start_hazard", 64'(hazard_out), 1);
    chk("busy_start_busy", 64'(busy_out), 1);
    push(2, 1, T_WR, 1); drive(1'b1, 1'b1, 2, 255);
    chk("capture_frame1", 64'(frame_idx_out), 1);
    drive(1'b0, 1'b0, 0, 0);

    // Reset mid-CAPTURE, between clock edges.
    #2 rst_n_in = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(request_valid_out), 0);
    chk("mid_rst_addr", 64'(addr_out), 0);
    chk("mid_rst_type", 64'(request_type_out), 64'(READ));
    chk("mid_rst_summand", 64'(summand_out), 0);
    chk("mid_rst_frame_idx", 64'(frame_idx_out), 0);
    chk("mid_rst_busy", 64'(busy_out), 0);
    chk("mid_rst_hazard", 64'(hazard_out), 0);
    chk("mid_rst_done", 64'(done_out), 0);
    tick();
    rst_n_in = 1'b1;
    repeat (2) tick();

    chk("sb_drained_end", 64'(sb.size()), 0);
    chk("done_count_end", 64'(done_pulses), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
